// File: rtl/elevator_pkg.sv
// elevator_pkg: floor labels, FSM states and the
// floor-to-one-hot decode shared by the elevator blocks.
package elevator_pkg;

  typedef logic [1:0] floor_t;

  localparam floor_t F1 = 2'd0;
  localparam floor_t F2 = 2'd1;
  localparam floor_t F3 = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  function automatic logic [2:0] floor_onehot(floor_t f);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (1'b1)
      (f == F1): oh = 3'b001;
      (f == F2): oh = 3'b010;
      (f == F3): oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: call buttons in, indicator
// and lamp outputs back to the panel.
interface elevator_scheduler_if;
  import elevator_pkg::*;

  logic [2:0] req;
  logic [2:0] pending;
  floor_t     floor;
  logic [2:0] floor_oh;
  floor_t     goal;
  logic       dir_up;
  logic       moving;
  logic       door_open;

  modport master (
    output req,
    input  pending, floor, floor_oh, goal,
    input  dir_up, moving, door_open
  );

  modport slave (
    input  req,
    output pending, floor, floor_oh, goal,
    output dir_up, moving, door_open
  );

endinterface

// File: rtl/elevator_tick_timer.sv
// elevator_tick_timer: counts 0..TICKS-1 while run is
// high and pulses done on the terminal count.
module elevator_tick_timer #(
  parameter int TICKS = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic done
);

  localparam int W = $clog2(TICKS + 1);
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt;

  // a restart request beats the terminal count
  assign done = run && !restart && (cnt == LAST);

  // count while running, reload on stop, restart or done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || restart || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: three-floor SCAN controller with
// request latch, travel timer and door dwell timer.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int MOVE_TICKS = 5,
  parameter int DOOR_TICKS = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  elevator_scheduler_if.slave bus
);

  state_t     state, state_n;
  floor_t     floor, floor_n, nf, goal;
  logic       dir_up, dir_n, dir_eff, dir_use;
  logic [2:0] pending, pending_n;
  logic [2:0] clr, mask, here, nf_oh;
  logic [2:0] ahead, behind;
  logic       move_done, door_done, restart;

  function automatic logic [2:0] side(floor_t f, logic up);
    logic [2:0] m;
    m = '0;
    for (int i = 0; i < 3; i++)
      m[i] = up ? (i > int'(f)) : (i < int'(f));
    return m;
  endfunction

  function automatic floor_t nearest(logic [2:0] m,
                                     logic low_first);
    floor_t r;
    r = F1;
    if (low_first) begin
      for (int i = 2; i >= 0; i--)
        if (m[i]) r = floor_t'(i);
    end else begin
      for (int i = 0; i < 3; i++)
        if (m[i]) r = floor_t'(i);
    end
    return r;
  endfunction

  assign here  = floor_onehot(floor);
  assign nf    = dir_up ? floor + 2'd1 : floor - 2'd1;
  assign nf_oh = floor_onehot(nf);

  // direction is clamped at the end floors when idle
  assign dir_eff = (floor == F3) ? 1'b0 :
                   (floor == F1) ? 1'b1 : dir_up;
  assign dir_use = (state == IDLE) ? dir_eff : dir_up;

  assign ahead  = pending & side(floor, dir_use);
  assign behind = pending & side(floor, !dir_use);

  assign goal = (|ahead)  ? nearest(ahead, dir_use)   :
                (|behind) ? nearest(behind, !dir_use) :
                floor;

  assign restart = (state == DOOR) && (|(bus.req & here));

  elevator_tick_timer #(.TICKS(MOVE_TICKS)) u_move (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == MOVE),
    .restart (1'b0),
    .done    (move_done)
  );

  elevator_tick_timer #(.TICKS(DOOR_TICKS)) u_door (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == DOOR),
    .restart (restart),
    .done    (door_done)
  );

  // next state, floor, direction and request latch
  always_comb begin
    state_n = state;
    floor_n = floor;
    dir_n   = dir_up;
    clr     = '0;
    mask    = '0;
    unique case (state)
      IDLE: begin
        dir_n = dir_eff;
        if (|((pending | bus.req) & here)) begin
          state_n = DOOR;
          clr     = here;
        end else if (|ahead) begin
          state_n = MOVE;
        end else if (|behind) begin
          dir_n   = !dir_eff;
          state_n = MOVE;
        end
      end
      MOVE: begin
        if (move_done) begin
          floor_n = nf;
          if (|(pending & nf_oh)) begin
            state_n = DOOR;
            clr     = nf_oh;
          end else if (!(|(pending & side(nf, dir_up)))) begin
            state_n = IDLE;
          end
        end
      end
      DOOR: begin
        mask = here;
        if (door_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    pending_n = (pending | (bus.req & ~mask)) & ~clr;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      floor   <= F1;
      dir_up  <= 1'b1;
      pending <= '0;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      dir_up  <= dir_n;
      pending <= pending_n;
    end
  end

  assign bus.pending   = pending;
  assign bus.floor     = floor;
  assign bus.floor_oh  = here;
  assign bus.goal      = goal;
  assign bus.dir_up    = dir_up;
  assign bus.moving    = (state == MOVE);
  assign bus.door_open = (state == DOOR);

endmodule
